parking_session_tracker: RTL and testbench
==========================================

Name: parking_session_tracker

Overview:
- Upstream of the fee calculator; owns the parking-time base and a table of open parking sessions.
- Each vehicle entry stores the vehicle ID and a timestamp.
- On vehicle exit the block finds the session and issues a one-cycle fee request to the fee calculator. It then waits for the fee result, frees the slot and reports the fee.

Parameters:
- MAX_VEHICLES, 8: number of session slots.
- TICK_DIV, 1: clocks per time unit; cur_time increments once every TICK_DIV clocks.
- TIMEOUT_CYCLES, 64: fee wait limit; used only with FEE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vehicle_entry  in  1  entry event strobe.
- vehicle_exit  in  1  exit event strobe.
- vehicle_id_in  in  8  ID for the event.
- ready  out  1  block is in IDLE and an event will be accepted.
- entry_time  out  32  fee request: stored entry timestamp.
- exit_time  out  32  fee request: cur_time captured at exit.
- vehicle_id  out  8  fee request: ID.
- calculate_fee  out  1  one-cycle fee request pulse.
- fee_amount  in  8  fee calculator result.
- fee_valid  in  1  fee calculator result valid.
- entry_ack  out  1  one-cycle pulse: entry stored.
- fee_out  out  8  fee for the departed vehicle.
- fee_done  out  1  one-cycle pulse: fee_out and done_id valid.
- done_id  out  8  ID of the departed vehicle.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  error code: 1 = table full, 2 = duplicate entry, 3 = unknown exit, 4 = fee timeout.
- occupancy  out  $clog2(MAX_VEHICLES)+1  number of valid slots.
- cur_time  out  32  current timestamp.

Behaviour:
- Reset (asynchronous, active-high), including mid-operation:
  - All slots are invalidated; FSM goes to IDLE.
  - cur_time, prescaler, entry_time, exit_time, vehicle_id, fee_out, done_id, err_code and occupancy are 0.
  - calculate_fee, entry_ack, fee_done and err_valid are 0; ready is 1 after reset releases.
- Time base:
  - A prescaler counts 0..TICK_DIV-1; cur_time increments when the prescaler equals TICK_DIV-1.
  - cur_time wraps 0xFFFFFFFF to 0. No wrap correction is applied; wrapped sessions are handled by the fee calculator's exit<entry rule.
  - The time base runs in every state.
- FSM states: IDLE, SCAN, RESOLVE, REQUEST, WAIT_FEE.
- IDLE:
  - ready=1.
  - An event is accepted on a rising edge when vehicle_exit or vehicle_entry is high. vehicle_id_in and the event type are latched.
  - If both strobes are high, the exit is accepted and the entry is dropped silently.
  - Next state: SCAN.
- Outside IDLE: ready=0 and strobes are ignored with no side effects.
- SCAN:
  - Examines exactly one slot per cycle, index 0 to MAX_VEHICLES-1, always a full pass.
  - Records the hit (valid slot with matching ID) and the lowest-index free slot.
  - Then goes to RESOLVE.
- RESOLVE, entry event:
  - Hit: err code 2, return to IDLE.
  - No hit and no free slot: err code 1, return to IDLE.
  - Otherwise: write {valid, ID, cur_time} to the lowest free slot, pulse entry_ack, increment occupancy, return to IDLE.
  - Latency from the accept edge to entry_ack high is MAX_VEHICLES+1 clocks.
- RESOLVE, exit event:
  - Miss: err code 3, return to IDLE.
  - Hit: load entry_time from the slot, exit_time=cur_time, vehicle_id=latched ID; go to REQUEST.
- REQUEST:
  - calculate_fee=1 for exactly one cycle; go to WAIT_FEE.
  - entry_time, exit_time and vehicle_id hold stable until the FSM returns to IDLE.
- WAIT_FEE:
  - On the first cycle with fee_valid=1: fee_out=fee_amount, done_id=ID, fee_done pulse, clear the slot, decrement occupancy, go to IDLE.
  - fee_valid seen in any other state is ignored.
- Error reporting: err_valid pulses for one cycle; err_code holds its value until the next error or reset.
- Occupancy bounds: occupancy never exceeds MAX_VEHICLES and never goes below 0.

Optional Feature:
- FEE_TIMEOUT_EN defined:
  - A counter runs in WAIT_FEE. If fee_valid has not arrived after TIMEOUT_CYCLES clocks: err code 4, no fee_done, slot kept valid (the vehicle may retry its exit), return to IDLE.
- FEE_TIMEOUT_EN undefined:
  - WAIT_FEE waits indefinitely; TIMEOUT_CYCLES is unused and error code 4 is never produced.

Test Plan:
- MAX_VEHICLES=4, TICK_DIV=1: reset, entry ID 5 accepted at cur_time=10 -> entry_ack 5 clocks later, occupancy=1, slot 0 entry timestamp 10.
- Entry ID 5, then exit ID 5 at cur_time=70 -> one calculate_fee pulse with entry_time=10, exit_time=70, vehicle_id=5; model returns fee_valid with fee_amount=15 -> fee_done, fee_out=15, done_id=5, occupancy=0.
- Enter IDs 1,2,3,4, then entry ID 6 -> err_valid, err_code=1, occupancy stays 4. Entry ID 2 again -> err_code=2. Exit ID 9 -> err_code=3.
- Vehicle_entry and vehicle_exit together, ID 3 (present) -> exit is processed, no entry_ack.
- Strobes asserted while ready=0 are ignored. Reset asserted in WAIT_FEE -> all outputs 0 at once, occupancy 0, a later exit of the same ID gives err_code=3.
- With FEE_TIMEOUT_EN and fee_valid withheld -> err_code=4 exactly TIMEOUT_CYCLES clocks after entering WAIT_FEE, occupancy unchanged. Cross-check: TICK_DIV=4 makes cur_time advance by 1 every 4 clocks.

Source files
------------

// File: rtl/parking_session_tracker.sv
// ----------------------------------------------------------------------------
// parking_session_tracker
//
// Owns the parking time base and a table of open parking sessions. An entry
// event stores {vehicle ID, timestamp} in the lowest free slot. An exit event
// looks the session up, issues a one-cycle fee request to the downstream fee
// calculator, waits for the fee result, then frees the slot and reports the
// fee.
//
// Optional build macro: FEE_TIMEOUT_EN
//   defined   : WAIT_FEE gives up after TIMEOUT_CYCLES clocks (err_code 4),
//               the session stays open so the vehicle may retry its exit.
//   undefined : WAIT_FEE waits indefinitely; TIMEOUT_CYCLES is unused.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   vehicle_entry     : entry event strobe (sampled only while ready=1)
//   vehicle_exit      : exit event strobe (wins over a coincident entry)
//   vehicle_id_in     : vehicle ID for the event
//   ready             : FSM idle, an event will be accepted
//   entry_time        : fee request - stored entry timestamp
//   exit_time         : fee request - timestamp captured at exit
//   vehicle_id        : fee request - vehicle ID
//   calculate_fee     : one-cycle fee request pulse
//   fee_amount        : fee calculator result
//   fee_valid         : fee calculator result valid (used only in WAIT_FEE)
//   entry_ack         : one-cycle pulse, entry stored
//   fee_out, done_id  : fee and ID of the departed vehicle
//   fee_done          : one-cycle pulse, fee_out/done_id valid
//   err_valid         : one-cycle error pulse
//   err_code          : 1 full, 2 duplicate, 3 unknown exit, 4 fee timeout
//   occupancy         : number of open sessions
//   cur_time          : current timestamp
// ----------------------------------------------------------------------------
module parking_session_tracker #(
    parameter int MAX_VEHICLES   = 8,
    parameter int TICK_DIV       = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            vehicle_entry,
    input  logic                            vehicle_exit,
    input  logic [7:0]                      vehicle_id_in,
    output logic                            ready,
    output logic [31:0]                     entry_time,
    output logic [31:0]                     exit_time,
    output logic [7:0]                      vehicle_id,
    output logic                            calculate_fee,
    input  logic [7:0]                      fee_amount,
    input  logic                            fee_valid,
    output logic                            entry_ack,
    output logic [7:0]                      fee_out,
    output logic                            fee_done,
    output logic [7:0]                      done_id,
    output logic                            err_valid,
    output logic [2:0]                      err_code,
    output logic [$clog2(MAX_VEHICLES):0]   occupancy,
    output logic [31:0]                     cur_time
);

    localparam int IDX_W = (MAX_VEHICLES > 1) ? $clog2(MAX_VEHICLES) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OCC_W = $clog2(MAX_VEHICLES) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_VEHICLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_VEHICLES);

    localparam logic [2:0] ERR_FULL    = 3'd1;
    localparam logic [2:0] ERR_DUP     = 3'd2;
    localparam logic [2:0] ERR_UNKNOWN = 3'd3;

    // Reject meaningless configurations at elaboration time.
    if (MAX_VEHICLES < 2 || TICK_DIV < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("parking_session_tracker: invalid parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        RESOLVE,
        REQUEST,
        WAIT_FEE
    } state_t;

    state_t state, state_nxt;

    // Session table
    logic [MAX_VEHICLES-1:0] slot_valid;
    logic [7:0]              slot_id   [MAX_VEHICLES];
    logic [31:0]             slot_time [MAX_VEHICLES];

    // Latched event and scan results
    logic             ev_exit;
    logic [7:0]       ev_id;
    logic [31:0]      ev_time;
    logic [IDX_W-1:0] scan_idx;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    logic [PRE_W-1:0] prescaler;

    logic accept;
    logic scan_last;
    logic scan_hit;
    logic entry_ok;
    logic fee_timeout;

    assign accept    = ready && (vehicle_entry || vehicle_exit);
    assign scan_last = (scan_idx == LAST_IDX);
    assign scan_hit  = slot_valid[scan_idx] && (slot_id[scan_idx] == ev_id);
    assign entry_ok  = (state == RESOLVE) && !ev_exit && !hit && free_found;

`ifdef FEE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      ERR_TIMEOUT = 3'd4;

    logic [TO_W-1:0] to_cnt;

    assign fee_timeout = (state == WAIT_FEE) && !fee_valid && (to_cnt == TO_LAST);

    // Counts clocks spent in WAIT_FEE; parked at zero everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != WAIT_FEE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign fee_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Time base: runs in every state, wraps naturally at 32 bits.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            cur_time  <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            cur_time  <= cur_time + 32'd1;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        ready         = 1'b0;
        calculate_fee = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (vehicle_entry || vehicle_exit) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                state_nxt = (ev_exit && hit) ? REQUEST : IDLE;
            end
            REQUEST: begin
                calculate_fee = 1'b1;
                state_nxt     = WAIT_FEE;
            end
            WAIT_FEE: begin
                if (fee_valid || fee_timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: event latch, scan, session bookkeeping, result reporting
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            ev_exit    <= 1'b0;
            ev_id      <= '0;
            ev_time    <= '0;
            scan_idx   <= '0;
            hit        <= 1'b0;
            hit_idx    <= '0;
            free_found <= 1'b0;
            free_idx   <= '0;
            entry_time <= '0;
            exit_time  <= '0;
            vehicle_id <= '0;
            fee_out    <= '0;
            done_id    <= '0;
            err_code   <= '0;
            occupancy  <= '0;
            entry_ack  <= 1'b0;
            fee_done   <= 1'b0;
            err_valid  <= 1'b0;
        end else begin
            // Pulses default low and are raised for a single cycle below.
            entry_ack <= 1'b0;
            fee_done  <= 1'b0;
            err_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        // Exit wins over a coincident entry. The event's
                        // timestamp is the time at which it was accepted.
                        ev_exit    <= vehicle_exit;
                        ev_id      <= vehicle_id_in;
                        ev_time    <= cur_time;
                        scan_idx   <= '0;
                        hit        <= 1'b0;
                        free_found <= 1'b0;
                    end
                end

                SCAN: begin
                    if (scan_hit) begin
                        hit     <= 1'b1;
                        hit_idx <= scan_idx;
                    end
                    // Slots are visited in ascending order, so the first free
                    // one seen is the lowest-index free slot.
                    if (!slot_valid[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (!scan_last) begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end

                RESOLVE: begin
                    if (ev_exit) begin
                        if (hit) begin
                            entry_time <= slot_time[hit_idx];
                            exit_time  <= ev_time;
                            vehicle_id <= ev_id;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_UNKNOWN;
                        end
                    end else if (hit) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_DUP;
                    end else if (!free_found) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_FULL;
                    end else begin
                        slot_valid[free_idx] <= 1'b1;
                        entry_ack            <= 1'b1;
                        if (occupancy < OCC_MAX) begin
                            occupancy <= occupancy + OCC_W'(1);
                        end
                    end
                end

                WAIT_FEE: begin
                    if (fee_valid) begin
                        fee_out             <= fee_amount;
                        done_id             <= ev_id;
                        fee_done            <= 1'b1;
                        slot_valid[hit_idx] <= 1'b0;
                        if (occupancy != '0) begin
                            occupancy <= occupancy - OCC_W'(1);
                        end
                    end
`ifdef FEE_TIMEOUT_EN
                    else if (fee_timeout) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                    end
`endif
                end

                default: ;
            endcase
        end
    end

    // NOTE: the slot payload is deliberately not reset; slot_valid qualifies
    // it, and leaving the array reset-free lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (entry_ok) begin
            slot_id[free_idx]   <= ev_id;
            slot_time[free_idx] <= ev_time;
        end
    end

endmodule

// File: tb/tb_parking_session_tracker.sv
// ----------------------------------------------------------------------------
// Self-checking bench for parking_session_tracker (MAX_VEHICLES=4, TICK_DIV=1)
// with a second TICK_DIV=4 instance for the time-base cross-check.
// Directed table vectors, hand-written corner sequences, then randomized
// events checked against a session-list reference model.
// ----------------------------------------------------------------------------
module tb_parking_session_tracker;

    localparam int MAXV   = 4;
    localparam int TDIV   = 1;
    localparam int TO_CYC = 16;
    localparam int OW     = $clog2(MAXV) + 1;
    localparam int LAT    = MAXV + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vehicle_entry = 1'b0;
    logic        vehicle_exit = 1'b0;
    logic [7:0]  vehicle_id_in = '0;
    logic [7:0]  fee_amount = '0;
    logic        fee_valid = 1'b0;

    logic        ready, calculate_fee, entry_ack, fee_done, err_valid;
    logic [31:0] entry_time, exit_time, cur_time;
    logic [7:0]  vehicle_id, fee_out, done_id;
    logic [2:0]  err_code;
    logic [OW-1:0] occupancy;

    // TICK_DIV=4 instance, only its time base is observed
    logic        d4_ready, d4_calc, d4_ack, d4_done, d4_errv;
    logic [31:0] d4_et, d4_xt, d4_cur;
    logic [7:0]  d4_vid, d4_fee, d4_did;
    logic [2:0]  d4_code;
    logic [OW-1:0] d4_occ;

    always #5 clk = ~clk;

    parking_session_tracker #(
        .MAX_VEHICLES(MAXV), .TICK_DIV(TDIV), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .vehicle_entry(vehicle_entry), .vehicle_exit(vehicle_exit),
        .vehicle_id_in(vehicle_id_in), .ready(ready),
        .entry_time(entry_time), .exit_time(exit_time), .vehicle_id(vehicle_id),
        .calculate_fee(calculate_fee), .fee_amount(fee_amount), .fee_valid(fee_valid),
        .entry_ack(entry_ack), .fee_out(fee_out), .fee_done(fee_done),
        .done_id(done_id), .err_valid(err_valid), .err_code(err_code),
        .occupancy(occupancy), .cur_time(cur_time)
    );

    parking_session_tracker #(
        .MAX_VEHICLES(MAXV), .TICK_DIV(4), .TIMEOUT_CYCLES(TO_CYC)
    ) u_div4 (
        .clk(clk), .reset(reset),
        .vehicle_entry(1'b0), .vehicle_exit(1'b0),
        .vehicle_id_in(8'd0), .ready(d4_ready),
        .entry_time(d4_et), .exit_time(d4_xt), .vehicle_id(d4_vid),
        .calculate_fee(d4_calc), .fee_amount(8'd0), .fee_valid(1'b0),
        .entry_ack(d4_ack), .fee_out(d4_fee), .fee_done(d4_done),
        .done_id(d4_did), .err_valid(d4_errv), .err_code(d4_code),
        .occupancy(d4_occ), .cur_time(d4_cur)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: elapsed clocks since reset and a list of open sessions
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0]  id;
        logic [31:0] t;
    } sess_t;

    typedef enum int {K_NONE, K_ACK, K_ERR, K_FEE} kind_t;

    sess_t q[$];
    int    m_cyc;

    always @(posedge clk or posedge reset) begin
        if (reset) m_cyc <= 0;
        else       m_cyc <= m_cyc + 1;
    end

    function automatic logic [31:0] mtime(input int div);
        return 32'(m_cyc / div);
    endfunction

    function automatic int find(input logic [7:0] id);
        foreach (q[i]) if (q[i].id == id) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic send(input logic en, input logic ex, input logic [7:0] id,
                        input int wait_t, output logic [31:0] ev_t);
        int guard;
        @(negedge clk);
        for (int g = 0; g < 20000 && int'(mtime(TDIV)) < wait_t; g++) @(negedge clk);
        guard = 0;
        while (!ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("ready before event", ready, 1);
        check("cur_time", cur_time, mtime(TDIV));
        check("cur_time tick_div4", d4_cur, mtime(4));
        vehicle_entry = en;
        vehicle_exit  = ex;
        vehicle_id_in = id;
        ev_t = mtime(TDIV);
        @(posedge clk);
        #1;
        vehicle_entry = 1'b0;
        vehicle_exit  = 1'b0;
    endtask

    task automatic collect(output kind_t k, output int lat);
        k   = K_NONE;
        lat = 0;
        for (int i = 1; i <= 30 && k == K_NONE; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (entry_ack)          k = K_ACK;
            else if (err_valid)     k = K_ERR;
            else if (calculate_fee) k = K_FEE;
        end
    endtask

    // Acts as the fee calculator once the request pulse has been seen.
    task automatic finish_fee(input logic [7:0] id, input logic [7:0] fee, input int dly);
        logic got;
        @(posedge clk);
        #1;
        check("calculate_fee one cycle", calculate_fee, 0);
        repeat (dly) @(posedge clk);
        @(negedge clk);
        fee_valid  = 1'b1;
        fee_amount = fee;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = fee_done;
        end
        check("fee_done seen", got, 1);
        check("fee_out", fee_out, fee);
        check("done_id", done_id, id);
        check("occupancy after fee", occupancy, q.size());
        check("ready after fee", ready, 1);
        @(negedge clk);
        fee_valid = 1'b0;
    endtask

    task automatic do_event(input logic en, input logic ex, input logic [7:0] id,
                            input int wait_t, input logic [7:0] fee, input int dly,
                            input kind_t exp_kind, input logic [2:0] exp_code);
        logic [31:0] ev_t;
        kind_t       k;
        int          lat;
        int          idx;
        sess_t       s;
        idx = find(id);
        send(en, ex, id, wait_t, ev_t);
        collect(k, lat);
        check("event outcome", k, exp_kind);
        check("event latency", lat, LAT);
        case (exp_kind)
            K_ERR: begin
                check("err_code", err_code, exp_code);
                check("occupancy after error", occupancy, q.size());
                @(posedge clk);
                #1;
                check("err_valid one cycle", err_valid, 0);
                check("err_code held", err_code, exp_code);
            end
            K_ACK: begin
                s.id = id;
                s.t  = ev_t;
                q.push_back(s);
                check("occupancy after entry", occupancy, q.size());
                @(posedge clk);
                #1;
                check("entry_ack one cycle", entry_ack, 0);
            end
            K_FEE: begin
                if (idx >= 0) begin
                    check("req entry_time", entry_time, q[idx].t);
                    q.delete(idx);
                end
                check("req exit_time", exit_time, ev_t);
                check("req vehicle_id", vehicle_id, id);
                finish_fee(id, fee, dly);
            end
            default: ;
        endcase
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic       en;
        logic       ex;
        logic [7:0] id;
        int         wait_t;
        logic [7:0] fee;
        kind_t      kind;
        logic [2:0] code;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] ev_t;
        kind_t       k;
        int          lat;
        int          idx;
        int          n;

        vecs[0] = '{1'b1, 1'b0, 8'd5, 10, 8'd0,  K_ACK, 3'd0};
        vecs[1] = '{1'b0, 1'b1, 8'd5, 70, 8'd15, K_FEE, 3'd0};
        vecs[2] = '{1'b1, 1'b0, 8'd1, 0,  8'd0,  K_ACK, 3'd0};
        vecs[3] = '{1'b1, 1'b0, 8'd2, 0,  8'd0,  K_ACK, 3'd0};
        vecs[4] = '{1'b1, 1'b0, 8'd3, 0,  8'd0,  K_ACK, 3'd0};
        vecs[5] = '{1'b1, 1'b0, 8'd4, 0,  8'd0,  K_ACK, 3'd0};
        vecs[6] = '{1'b1, 1'b0, 8'd6, 0,  8'd0,  K_ERR, 3'd1};
        vecs[7] = '{1'b1, 1'b0, 8'd2, 0,  8'd0,  K_ERR, 3'd2};
        vecs[8] = '{1'b0, 1'b1, 8'd9, 0,  8'd0,  K_ERR, 3'd3};
        vecs[9] = '{1'b1, 1'b1, 8'd3, 0,  8'd7,  K_FEE, 3'd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset times", {entry_time, exit_time}, 64'd0);
        check("reset misc", {vehicle_id, fee_out, done_id, err_code, occupancy,
                             calculate_fee, entry_ack, fee_done, err_valid}, '0);
        check("reset cur_time", cur_time, 0);
        reset = 1'b0;
        #1;
        check("ready after reset", ready, 1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_event(vecs[i].en, vecs[i].ex, vecs[i].id, vecs[i].wait_t,
                     vecs[i].fee, 1, vecs[i].kind, vecs[i].code);
        end

        // Strobes while busy are ignored: exit ID 1 with noisy strobes for ID 9
        idx = find(8'd1);
        send(1'b0, 1'b1, 8'd1, 0, ev_t);
        vehicle_entry = 1'b1;
        vehicle_exit  = 1'b1;
        vehicle_id_in = 8'd9;
        collect(k, lat);
        check("busy: outcome", k, K_FEE);
        check("busy: vehicle_id", vehicle_id, 1);
        if (idx >= 0) begin
            check("busy: entry_time", entry_time, q[idx].t);
            q.delete(idx);
        end
        check("busy: exit_time", exit_time, ev_t);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vehicle_entry = 1'b0;
        vehicle_exit  = 1'b0;
        finish_fee(8'd1, 8'd33, 0);
        do_event(1'b0, 1'b1, 8'd9, 0, 8'd0, 0, K_ERR, 3'd3);

        // Reset while waiting for the fee
        send(1'b0, 1'b1, 8'd2, 0, ev_t);
        collect(k, lat);
        check("rst: outcome", k, K_FEE);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst: times", {entry_time, exit_time}, 64'd0);
        check("rst: misc", {vehicle_id, fee_out, done_id, err_code, occupancy,
                            calculate_fee, entry_ack, fee_done, err_valid}, '0);
        check("rst: cur_time", cur_time, 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        #1;
        check("rst: ready", ready, 1);
        do_event(1'b0, 1'b1, 8'd2, 0, 8'd0, 0, K_ERR, 3'd3);

`ifdef FEE_TIMEOUT_EN
        // Fee withheld: timeout after TIMEOUT_CYCLES clocks in WAIT_FEE
        do_event(1'b1, 1'b0, 8'd7, 0, 8'd0, 0, K_ACK, 3'd0);
        send(1'b0, 1'b1, 8'd7, 0, ev_t);
        collect(k, lat);
        check("timeout: outcome", k, K_FEE);
        n = 0;
        for (int i = 1; i <= TO_CYC + 8 && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (err_valid || fee_done) n = i;
        end
        check("timeout: clocks", n, TO_CYC + 1);
        check("timeout: err_code", err_code, 4);
        check("timeout: no fee_done", fee_done, 0);
        check("timeout: occupancy", occupancy, q.size());
        do_event(1'b0, 1'b1, 8'd7, 0, 8'd21, 0, K_FEE, 3'd0);
`endif

        // Randomized events against the session model
        for (int it = 0; it < 40; it++) begin
            int          r;
            logic        en, ex;
            logic [7:0]  id;
            kind_t       ek;
            logic [2:0]  ec;
            r  = $urandom_range(0, 9);
            id = 8'($urandom_range(1, 6));
            en = (r == 0) || (r >= 5);
            ex = (r <= 4);
            ec = 3'd0;
            if (ex)                      ek = (find(id) >= 0) ? K_FEE : K_ERR;
            else if (find(id) >= 0)      ek = K_ERR;
            else if (q.size() >= MAXV)   ek = K_ERR;
            else                         ek = K_ACK;
            if (ek == K_ERR) begin
                if (ex)                 ec = 3'd3;
                else if (find(id) >= 0) ec = 3'd2;
                else                    ec = 3'd1;
            end
            n = $urandom_range(0, 3);
            repeat (n) @(negedge clk);
            do_event(en, ex, id, 0, 8'($urandom), $urandom_range(0, 4), ek, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
